// File: rtl/led_ctrl_pkg.sv
// Shared constants and frame FSM encoding for the LED frame scheduler.
package led_ctrl_pkg;

    localparam int NUM_LEDS = 8;
    localparam int COLOR_W  = 24;
    localparam int IDX_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        WAIT_HI,
        WAIT_LO
    } frame_state_e;

endpackage

// File: rtl/led_wr_arbiter.sv
// Two-way round-robin write arbiter (host vs status) with a block input.
module led_wr_arbiter
    import led_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               block_i,
    input  logic               host_req_i,
    input  logic [IDX_W-1:0]   host_idx_i,
    input  logic [COLOR_W-1:0] host_color_i,
    input  logic               stat_req_i,
    input  logic [IDX_W-1:0]   stat_idx_i,
    input  logic [COLOR_W-1:0] stat_color_i,
    output logic               grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [COLOR_W-1:0] color_o,
    output logic               host_ack_o,
    output logic               stat_ack_o
);

    // Remembers who won last so a conflict goes to the other port.
    logic last_stat_q, last_stat_d;
    logic host_ok, stat_ok;

    always_comb begin
        host_ok     = host_req_i && !block_i;
        stat_ok     = stat_req_i && !block_i;
        host_ack_o  = host_ok && (!stat_ok || last_stat_q);
        stat_ack_o  = stat_ok && (!host_ok || !last_stat_q);
        grant_o     = host_ack_o || stat_ack_o;
        idx_o       = host_ack_o ? host_idx_i : stat_idx_i;
        color_o     = host_ack_o ? host_color_i : stat_color_i;
        last_stat_d = last_stat_q;
        if (host_ack_o)
            last_stat_d = 1'b0;
        else if (stat_ack_o)
            last_stat_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_stat_q <= 1'b1;
        else
            last_stat_q <= last_stat_d;
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// Shadow/active LED colour store with refresh timer and frame launch FSM
// handshaking with the serial WS2812 driver.
module led_frame_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int REFRESH_CYCLES = 1_000_000,
    parameter int BUSY_TIMEOUT   = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        force_refresh,
    input  logic                        host_req,
    input  logic [IDX_W-1:0]            host_idx,
    input  logic [COLOR_W-1:0]          host_color,
    output logic                        host_ack,
    input  logic                        stat_req,
    input  logic [IDX_W-1:0]            stat_idx,
    input  logic [COLOR_W-1:0]          stat_color,
    output logic                        stat_ack,
    output logic                        ser_start,
    input  logic                        ser_busy,
    output logic [NUM_LEDS*COLOR_W-1:0] led_active,
    output logic [15:0]                 frame_count,
    output logic                        timeout_err
);

    localparam int TMR_W = $clog2(REFRESH_CYCLES + 1);
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

    frame_state_e state_q, state_d;

    logic [NUM_LEDS-1:0][COLOR_W-1:0] shadow_q, shadow_d;
    logic [NUM_LEDS-1:0][COLOR_W-1:0] active_q, active_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [15:0]        frames_q, frames_d;
    logic               dirty_q, dirty_d;
    logic               pending_q, pending_d;
    logic               err_q, err_d;
    logic               tick, trigger, to_hit, block;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [COLOR_W-1:0] wr_color;

    led_wr_arbiter u_arb (
        .clk          (clk),
        .reset        (reset),
        .block_i      (block),
        .host_req_i   (host_req),
        .host_idx_i   (host_idx),
        .host_color_i (host_color),
        .stat_req_i   (stat_req),
        .stat_idx_i   (stat_idx),
        .stat_color_i (stat_color),
        .grant_o      (wr_en),
        .idx_o        (wr_idx),
        .color_o      (wr_color),
        .host_ack_o   (host_ack),
        .stat_ack_o   (stat_ack)
    );

    // force_refresh triggers directly as well as via pending, so a pulse in
    // IDLE reaches START two cycles later.
    assign tick    = enable && (timer_q == TMR_W'(REFRESH_CYCLES - 1));
    assign trigger = enable && (pending_q || force_refresh || (tick && dirty_q));
    assign to_hit  = (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger) state_d = LATCH;
            LATCH:   state_d = START;
            START:   state_d = WAIT_HI;
            WAIT_HI: begin
                if (ser_busy)
                    state_d = WAIT_LO;
                else if (to_hit)
                    state_d = IDLE;
            end
            WAIT_LO: if (!ser_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ser_start = (state_q == START);
        block     = (state_q == LATCH);
    end

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        dirty_d   = dirty_q;
        pending_d = pending_q;
        to_cnt_d  = to_cnt_q;
        frames_d  = frames_q;
        err_d     = err_q;
        timer_d   = '0;
        if (enable)
            timer_d = tick ? '0 : timer_q + 1'b1;
        if (wr_en) begin
            shadow_d[wr_idx] = wr_color;
            dirty_d          = 1'b1;
        end
        if (state_q == IDLE && trigger)
            pending_d = 1'b0;
        else if (force_refresh)
            pending_d = 1'b1;
        case (state_q)
            LATCH: begin
                active_d = shadow_q;
                dirty_d  = 1'b0;
            end
            START:   to_cnt_d = '0;
            WAIT_HI: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (!ser_busy && to_hit)
                    err_d = 1'b1;
            end
            WAIT_LO: if (!ser_busy) frames_d = frames_q + 16'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            timer_q   <= '0;
            to_cnt_q  <= '0;
            frames_q  <= '0;
            dirty_q   <= 1'b0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            timer_q   <= timer_d;
            to_cnt_q  <= to_cnt_d;
            frames_q  <= frames_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign led_active  = active_q;
    assign frame_count = frames_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler: arbitration table, directed
// frame/timeout/reset sequences, then randomized traffic against a model.
module tb_led_frame_scheduler;

    localparam int RC = 100;
    localparam int BT = 16;

    logic         clk = 1'b0;
    logic         reset, enable, force_refresh, ser_busy;
    logic         host_req, stat_req, host_ack, stat_ack, ser_start, timeout_err;
    logic [2:0]   host_idx, stat_idx;
    logic [23:0]  host_color, stat_color;
    logic [191:0] led_active;
    logic [15:0]  frame_count;

    int total = 0, bad = 0, start_cnt = 0, falls = 0;
    logic auto_resp = 1'b1, rnd_resp = 1'b0;
    int resp_dly = 2, busy_len = 4;

    led_frame_scheduler #(.NUM_LEDS(8), .REFRESH_CYCLES(RC), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .force_refresh(force_refresh),
        .host_req(host_req), .host_idx(host_idx), .host_color(host_color), .host_ack(host_ack),
        .stat_req(stat_req), .stat_idx(stat_idx), .stat_color(stat_color), .stat_ack(stat_ack),
        .ser_start(ser_start), .ser_busy(ser_busy), .led_active(led_active),
        .frame_count(frame_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chkw(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chkw(nm, {191'd0, act}, {191'd0, exp});
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [191:0] pack(input logic [23:0] sh [8]);
        logic [191:0] p;
        for (int i = 0; i < 8; i++) p[i*24 +: 24] = sh[i];
        return p;
    endfunction

    // Serial driver stand-in: raises busy some cycles after each start pulse.
    initial begin
        int rc, bc;
        logic prev_st;
        rc = 0; bc = 0; prev_st = 1'b0; ser_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ser_start) begin
                total++;
                if (prev_st) begin
                    bad++;
                    $display("FAIL start_width: got 2+ cycles want 1");
                end
            end
            prev_st = ser_start;
            if (reset) begin
                ser_busy = 1'b0; rc = 0; bc = 0;
            end else if (ser_start) begin
                start_cnt++;
                if (auto_resp) rc = rnd_resp ? int'($urandom_range(1, 8)) : resp_dly;
            end else if (rc > 0) begin
                rc--;
                if (rc == 0) begin
                    ser_busy = 1'b1;
                    bc = rnd_resp ? int'($urandom_range(1, 6)) : busy_len;
                end
            end else if (bc > 0) begin
                bc--;
                if (bc == 0) begin
                    ser_busy = 1'b0;
                    falls++;
                end
            end
        end
    end

    task automatic host_wr(input logic [2:0] i, input logic [23:0] c, input string nm);
        host_req = 1'b1; host_idx = i; host_color = c;
        #1 chk1(nm, host_ack, 1'b1);
        cyc();
        host_req = 1'b0;
    endtask

    task automatic wait_fc(input logic [15:0] want, input string nm);
        int k;
        k = 0;
        while (frame_count !== want && k < 100) begin
            cyc();
            k++;
        end
        chkw(nm, {176'd0, frame_count}, {176'd0, want});
    endtask

    task automatic force_start(input string nm);
        force_refresh = 1'b1;
        #1 chk1({nm, "_c0"}, ser_start, 1'b0);
        cyc();
        force_refresh = 1'b0;
        #1 chk1({nm, "_c1"}, ser_start, 1'b0);
        cyc();
        #1 chk1({nm, "_c2"}, ser_start, 1'b1);
    endtask

    task automatic wait_busy(input string nm);
        int k;
        k = 0;
        while (!ser_busy && k < 30) begin
            cyc();
            k++;
        end
        chk1(nm, ser_busy, 1'b1);
    endtask

    typedef struct {
        logic h, s;
        logic [2:0] hi, si;
        logic [23:0] hc, sc;
        logic eh, es;
    } vec_t;

    initial begin
        vec_t vt[8];
        logic [23:0] esh[8];
        logic [23:0] msh[8];
        logic [191:0] act0, prev_act;
        logic stable, mlast, blk_prev, eh, es, hdone, sdone;
        int s0, found, falls0;

        reset = 1'b1; enable = 1'b0; force_refresh = 1'b0;
        host_req = 1'b0; stat_req = 1'b0;
        host_idx = '0; stat_idx = '0; host_color = '0; stat_color = '0;
        cyc(3);
        chkw("rst_active", led_active, 192'd0);
        chkw("rst_frames", {176'd0, frame_count}, 192'd0);
        chk1("rst_err", timeout_err, 1'b0);
        chk1("rst_start", ser_start, 1'b0);
        chk1("rst_hack", host_ack, 1'b0);
        reset = 1'b0;
        cyc();

        // arbitration table; enable low so no frame starts meanwhile
        vt[0] = '{1, 0, 3'd1, 3'd0, 24'h111111, 24'h0,      1, 0};
        vt[1] = '{0, 1, 3'd0, 3'd2, 24'h0,      24'h222222, 0, 1};
        vt[2] = '{1, 1, 3'd3, 3'd4, 24'h333333, 24'h444444, 1, 0};
        vt[3] = '{1, 1, 3'd5, 3'd6, 24'h555555, 24'h666666, 0, 1};
        vt[4] = '{1, 1, 3'd7, 3'd0, 24'h777777, 24'hAAAAAA, 1, 0};
        vt[5] = '{0, 0, 3'd2, 3'd2, 24'h999999, 24'h999999, 0, 0};
        vt[6] = '{0, 1, 3'd0, 3'd0, 24'h0,      24'h0000BB, 0, 1};
        vt[7] = '{1, 1, 3'd6, 3'd2, 24'hCCCCCC, 24'hDDDDDD, 1, 0};
        for (int i = 0; i < 8; i++) esh[i] = 24'd0;
        for (int i = 0; i < 8; i++) begin
            host_req = vt[i].h; host_idx = vt[i].hi; host_color = vt[i].hc;
            stat_req = vt[i].s; stat_idx = vt[i].si; stat_color = vt[i].sc;
            #1;
            chkw($sformatf("arb_vec%0d", i), {190'd0, host_ack, stat_ack}, {190'd0, vt[i].eh, vt[i].es});
            if (vt[i].eh) esh[vt[i].hi] = vt[i].hc;
            if (vt[i].es) esh[vt[i].si] = vt[i].sc;
            cyc();
        end
        host_req = 1'b0; stat_req = 1'b0;
        chkw("no_frame_while_disabled", led_active, 192'd0);

        // host write then force: frame launched 2 cycles after force
        host_wr(3'd3, 24'h00FF00, "a_wr_ack");
        esh[3] = 24'h00FF00;
        enable = 1'b1; resp_dly = 3; busy_len = 4;
        force_start("a_force");
        chkw("a_led3", {168'd0, led_active[95:72]}, {168'd0, 24'h00FF00});
        chkw("a_all", led_active, pack(esh));
        wait_fc(16'd1, "a_frames");

        // refresh timer: clean shadow never launches; one write launches once
        s0 = start_cnt;
        cyc(500);
        chki("b_no_start_clean", start_cnt - s0, 0);
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        host_req = 1'b1; host_idx = 3'd5; host_color = 24'h0A0B0C;
        #1 chk1("b_wr_ack", host_ack, 1'b1);
        found = -1;
        for (int k = 1; k <= 150; k++) begin
            cyc();
            host_req = 1'b0;
            #1;
            if (ser_start && found < 0) found = k;
        end
        chki("b_tick_latency", found, RC + 1);
        chki("b_one_frame", start_cnt - s0, 1);
        esh[5] = 24'h0A0B0C;
        chkw("b_active", led_active, pack(esh));
        wait_fc(16'd2, "b_frames");

        // force with enable low is held pending until enable returns
        enable = 1'b0;
        s0 = start_cnt;
        force_refresh = 1'b1;
        cyc();
        force_refresh = 1'b0;
        cyc(10);
        chki("p_no_start_disabled", start_cnt - s0, 0);
        enable = 1'b1;
        #1 chk1("p_c0", ser_start, 1'b0);
        cyc();
        #1 chk1("p_c1", ser_start, 1'b0);
        cyc();
        #1 chk1("p_c2", ser_start, 1'b1);
        wait_fc(16'd3, "p_frames");

        // write + force while busy: active frozen, remembered force relaunches
        resp_dly = 2; busy_len = 10;
        force_start("c_force");
        wait_busy("c_busy");
        act0 = led_active;
        host_req = 1'b1; host_idx = 3'd0; host_color = 24'h123456; force_refresh = 1'b1;
        #1 chk1("c_wr_ack", host_ack, 1'b1);
        cyc();
        host_req = 1'b0; force_refresh = 1'b0;
        stable = 1'b1; found = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (ser_start) begin
                found = 1;
                break;
            end
            if (led_active !== act0) stable = 1'b0;
            cyc();
        end
        chk1("c_active_stable", stable, 1'b1);
        chk1("c_relaunch", found[0], 1'b1);
        chkw("c_new_active", led_active, {act0[191:24], 24'h123456});
        wait_fc(16'd5, "c_frames");

        // busy never rises: sticky timeout, back to IDLE, count unchanged
        auto_resp = 1'b0;
        force_start("d_force");
        cyc(15);
        chk1("d_err_early", timeout_err, 1'b0);
        cyc(2);
        chk1("d_err_set", timeout_err, 1'b1);
        chkw("d_frames_same", {176'd0, frame_count}, {176'd0, 16'd5});
        auto_resp = 1'b1; resp_dly = 2; busy_len = 3;
        force_start("d_idle_again");
        wait_fc(16'd6, "d_frames");
        chk1("d_err_sticky", timeout_err, 1'b1);

        // reset during WAIT_LO aborts the frame
        resp_dly = 1; busy_len = 20;
        force_start("e_force");
        wait_busy("e_busy");
        cyc(2);
        reset = 1'b1;
        cyc();
        chkw("e_active", led_active, 192'd0);
        chkw("e_frames", {176'd0, frame_count}, 192'd0);
        chk1("e_err", timeout_err, 1'b0);
        chk1("e_start", ser_start, 1'b0);
        chkw("e_acks", {190'd0, host_ack, stat_ack}, 192'd0);
        reset = 1'b0;
        s0 = start_cnt;
        cyc(20);
        chki("e_no_start", start_cnt - s0, 0);
        busy_len = 3;
        force_start("e_post");
        wait_fc(16'd1, "e_frames_post");

        // randomized traffic against a behavioural model
        for (int i = 0; i < 8; i++) msh[i] = 24'd0;
        mlast = 1'b1; blk_prev = 1'b0; hdone = 1'b0; sdone = 1'b0;
        rnd_resp = 1'b1; falls0 = falls; prev_act = led_active;
        for (int c = 0; c < 2500; c++) begin
            if (hdone) host_req = 1'b0;
            if (sdone) stat_req = 1'b0;
            if (!host_req && $urandom_range(0, 2) == 0) begin
                host_req = 1'b1; host_idx = 3'($urandom_range(0, 7)); host_color = 24'($urandom);
            end
            if (!stat_req && $urandom_range(0, 2) == 0) begin
                stat_req = 1'b1; stat_idx = 3'($urandom_range(0, 7)); stat_color = 24'($urandom);
            end
            force_refresh = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 199) == 0) enable = !enable;
            #1;
            if (blk_prev) chk1("rnd_block_then_start", ser_start, 1'b1);
            if (ser_start) chkw("rnd_active_latch", led_active, pack(msh));
            else chkw("rnd_active_hold", led_active, prev_act);
            prev_act = led_active;
            eh = host_req && (!stat_req || mlast);
            es = stat_req && (!host_req || !mlast);
            blk_prev = (host_req || stat_req) && !host_ack && !stat_ack;
            if (!blk_prev) begin
                chkw("rnd_ack", {190'd0, host_ack, stat_ack}, {190'd0, eh, es});
                if (eh) begin
                    msh[host_idx] = host_color;
                    mlast = 1'b0;
                end
                if (es) begin
                    msh[stat_idx] = stat_color;
                    mlast = 1'b1;
                end
            end
            hdone = host_ack;
            sdone = stat_ack;
            cyc();
        end
        host_req = 1'b0; stat_req = 1'b0; force_refresh = 1'b0; enable = 1'b0;
        cyc(40);
        chkw("rnd_frames", {176'd0, frame_count}, {176'd0, 16'(1 + falls - falls0)});
        chk1("rnd_no_timeout", timeout_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Sequences frame refreshes for the 8-LED WS2812-style chain and shares the LED colour store between two writers. The two writers are the host register interface and the status/indicator logic. A round-robin arbiter commits writes into a shadow colour buffer. A frame FSM copies shadow to active colours at a frame boundary, then launches the serial LED driver with a start/busy handshake. It sits between the register/status logic and the serial LED driver, and its active-colour outputs feed the driver's `led1..led8` inputs.

## Interface
Parameters:
- `NUM_LEDS`, 8: number of LEDs in the chain; index width is 3.
- `REFRESH_CYCLES`, 1_000_000: refresh period in clk cycles (10 ms at 100 MHz).
- `BUSY_TIMEOUT`, 4096: maximum cycles to wait for `ser_busy` to rise after `ser_start`.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: enables the refresh timer and launching of frames.
- `force_refresh`  in  1: single-cycle pulse requesting a frame regardless of the dirty flag.
- `host_req`  in  1: host write request; held until ack.
- `host_idx`  in  3: host target LED index.
- `host_color`  in  24: host colour, GRB order, MSB first.
- `host_ack`  out  1: host write committed this cycle.
- `stat_req`, `stat_idx`, `stat_color`, `stat_ack`: status port, same meaning as the host port.
- `ser_start`  out  1: single-cycle frame launch pulse to the serial driver.
- `ser_busy`  in  1: high while the serial driver is transmitting.
- `led_active`  out  192: active colours; LED0 is in [23:0].
- `frame_count`  out  16: number of completed frames; wraps at 2^16.
- `timeout_err`  out  1: sticky flag; set when `ser_busy` does not rise within the timeout.

## Operation
- Arbiter grant rules:
  - At most one write is granted per cycle.
  - If only one port requests, that port is granted.
  - If both request, the port not granted last time wins. The last-grant pointer resets to "stat", so host wins the first conflict.
- On a grant:
  - `shadow[idx] <= color`.
  - The granting port's ack is high that same cycle (combinational from req and state).
  - `dirty <= 1`.
- No grants are issued in the LATCH state. Requests simply wait there.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 while `enable` is high, and produces `tick` at the wrap.
  - Holds at 0 while `enable` is low.
- `force_refresh` sets a `pending` flag. The flag is cleared on entry to LATCH.
- FSM states:
  - IDLE: if `enable && (pending || (tick && dirty))`, go to LATCH.
  - LATCH (1 cycle): `led_active <= shadow`; `dirty <= 0`; `pending <= 0`; go to START.
  - START (1 cycle): `ser_start = 1`; clear the timeout counter; go to WAIT_HI.
  - WAIT_HI: if `ser_busy`, go to WAIT_LO. If the timeout counter reaches BUSY_TIMEOUT-1, set `timeout_err` and go to IDLE.
  - WAIT_LO: when `ser_busy` is low, increment `frame_count` and go to IDLE.
- Writes stay allowed during WAIT_HI and WAIT_LO. They change only the shadow buffer; `led_active` stays stable for the whole frame.
- A `tick` that arrives while not in IDLE is dropped. The next tick or a pending force triggers the next frame.
- A `force_refresh` during a frame is remembered and launches again on the return to IDLE.
- When `enable` is deasserted mid-frame, the current frame finishes. No new frame launches.
- `timeout_err` clears only on reset.

## Timing
- Reset values:
  - FSM in IDLE; timer = 0.
  - `shadow` and `led_active` all zero.
  - `dirty = 0`, `pending = 0`.
  - `ser_start = 0`, both acks 0.
  - `frame_count = 0`, `timeout_err = 0`.
- Reset asserted mid-frame aborts the frame immediately. No `ser_start` is issued after reset.
- Latencies:
  - Write ack is in the same cycle as the grant; shadow is updated on the following edge.
  - Trigger in IDLE → LATCH next cycle → `ser_start` high 2 cycles after the trigger cycle.
- A write granted in the same cycle as the IDLE→LATCH decision lands in shadow before LATCH samples it, so it is included in the frame.
- `ser_start` is exactly 1 cycle wide. `ser_busy` is expected to rise within BUSY_TIMEOUT cycles.

## Structure
- Package `led_ctrl_pkg`:
  - constants `NUM_LEDS`, `COLOR_W` = 24, `IDX_W` = 3;
  - FSM state typedef: IDLE, LATCH, START, WAIT_HI, WAIT_LO.
- Sub-module `led_wr_arbiter`: 2-way round-robin arbiter with a block input (driven high in LATCH). It outputs the grant, the selected index and colour, and both acks.
- The top level holds the shadow and active buffers, the timer, and the FSM.

## Test plan
- Host writes idx 3 = 0x00FF00, then a force pulse → `ser_start` 2 cycles after the force; `led_active[95:72]` = 0x00FF00; `frame_count` = 1 after `ser_busy` falls.
- Host and stat request in the same cycle three times in a row → grants go host, stat, host; exactly one ack per cycle.
- REFRESH_CYCLES = 100 with no writes → no `ser_start` across 500 cycles. One write → exactly one frame at the next tick.
- Shadow write to idx 0 while `ser_busy` is high → `led_active` unchanged until the next LATCH.
- `ser_busy` never rises, BUSY_TIMEOUT = 16 → `timeout_err` = 1 at 16 cycles after START, FSM back in IDLE, `frame_count` unchanged.
- Reset asserted in WAIT_LO → all outputs zero on the next cycle; no `ser_start` until a new trigger.
